// File: rtl/thinning_acceptor_if.sv
// Handshake bundle for the thinning acceptor: random-byte input, ratio input,
// decision output and the counter clear/readback signals.
interface thinning_acceptor_if #(
  parameter int UW    = 16,
  parameter int CNT_W = 16
);
  logic [7:0]       rnd_in;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [UW:0]      ratio_in;
  logic             ratio_valid;
  logic             ratio_ready;
  logic             dec_valid;
  logic             dec_ready;
  logic             dec_accept;
  logic [UW-1:0]    dec_u;
  logic             clr_cnt;
  logic [CNT_W-1:0] trial_cnt;
  logic [CNT_W-1:0] accept_cnt;

  modport master (
    output rnd_in, rnd_valid, ratio_in, ratio_valid, dec_ready, clr_cnt,
    input  rnd_ready, ratio_ready, dec_valid, dec_accept, dec_u, trial_cnt, accept_cnt
  );

  modport slave (
    input  rnd_in, rnd_valid, ratio_in, ratio_valid, dec_ready, clr_cnt,
    output rnd_ready, ratio_ready, dec_valid, dec_accept, dec_u, trial_cnt, accept_cnt
  );
endinterface

// File: rtl/thinning_acceptor.sv
// Ogata thinning acceptor: packs UW/8 LFSR bytes MSB-first into a uniform U and
// accepts the candidate iff U < ratio (UQ1.UW), with saturating trial/accept counts.
module thinning_acceptor #(
  parameter int UW    = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  thinning_acceptor_if.slave bus
);

  localparam int NB    = UW / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, GATHER, OUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [UW-1:0]      shift_q;
  logic [UW:0]        ratio_q;
  logic [UW-1:0]      dec_u_q;
  logic               dec_accept_q;
  logic [CNT_W-1:0]   trial_q, accept_q;

  logic               ratio_rdy, rnd_rdy, dec_vld;
  logic               ratio_take, byte_take, dec_take, last_byte;
  logic [UW-1:0]      u_next;
  logic               accept_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    ratio_rdy = 1'b0;
    rnd_rdy   = 1'b0;
    dec_vld   = 1'b0;
    case (state_q)
      IDLE: begin
        ratio_rdy = 1'b1;
        if (bus.ratio_valid) state_d = GATHER;
      end
      GATHER: begin
        rnd_rdy = 1'b1;
        if (bus.rnd_valid && last_byte) state_d = OUT;
      end
      OUT: begin
        dec_vld = 1'b1;
        if (bus.dec_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ratio_take = ratio_rdy & bus.ratio_valid;
  assign byte_take  = rnd_rdy & bus.rnd_valid;
  assign dec_take   = dec_vld & bus.dec_ready;
  assign last_byte  = (idx_q == IDX_W'(NB - 1));

  // The shift left drops the oldest byte harmlessly: after NB bytes every bit has been rewritten.
  assign u_next      = (shift_q << 8) | UW'(bus.rnd_in);
  assign accept_next = ({1'b0, u_next} < ratio_q);

  // Control and registered decision state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dec_u_q      <= '0;
      dec_accept_q <= 1'b0;
      trial_q      <= '0;
      accept_q     <= '0;
    end else begin
      state_q <= state_d;
      if (ratio_take) idx_q <= '0;
      if (byte_take) begin
        idx_q <= idx_q + IDX_W'(1);
        if (last_byte) begin
          dec_u_q      <= u_next;
          dec_accept_q <= accept_next;
        end
      end
      // Clear takes priority over a coincident decision handshake.
      if (bus.clr_cnt) begin
        trial_q  <= '0;
        accept_q <= '0;
      end else if (dec_take) begin
        trial_q <= sat_inc(trial_q);
        if (dec_accept_q) accept_q <= sat_inc(accept_q);
      end
    end
  end

  // Datapath holding registers, no reset needed
  always_ff @(posedge clk) begin
    if (ratio_take) ratio_q <= bus.ratio_in;
    if (byte_take)  shift_q <= u_next;
  end

  assign bus.ratio_ready = ratio_rdy;
  assign bus.rnd_ready   = rnd_rdy;
  assign bus.dec_valid   = dec_vld;
  assign bus.dec_u       = dec_u_q;
  assign bus.dec_accept  = dec_accept_q;
  assign bus.trial_cnt   = trial_q;
  assign bus.accept_cnt  = accept_q;

endmodule

// File: tb/tb_thinning_acceptor.sv
// Directed bench for thinning_acceptor: a 16-bit-counter instance for the main
// behaviour and a 4-bit-counter instance for saturation and clear.
module tb_thinning_acceptor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  thinning_acceptor_if #(.UW(16), .CNT_W(16)) a ();
  thinning_acceptor_if #(.UW(16), .CNT_W(4))  b ();

  thinning_acceptor #(.UW(16), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a));
  thinning_acceptor #(.UW(16), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ratio handshake then two bytes; leaves DUT A in OUT. dv_mid/dv_out sampled after edges 2 and 3.
  task automatic a_gather(input logic [16:0] r, input logic [7:0] b0, input logic [7:0] b1,
                          output logic dv_mid, output logic dv_out);
    a.ratio_in = r; a.ratio_valid = 1'b1;
    tick();
    a.ratio_valid = 1'b0; a.ratio_in = 17'h0;
    a.rnd_valid = 1'b1; a.rnd_in = b0;
    tick();
    dv_mid = a.dec_valid;
    a.rnd_in = b1;
    tick();
    dv_out = a.dec_valid;
    a.rnd_valid = 1'b0;
  endtask

  task automatic a_release();
    a.dec_ready = 1'b1;
    tick();
    a.dec_ready = 1'b0;
  endtask

  task automatic b_gather(input logic [16:0] r, input logic [7:0] b0, input logic [7:0] b1);
    b.ratio_in = r; b.ratio_valid = 1'b1;
    tick();
    b.ratio_valid = 1'b0;
    b.rnd_valid = 1'b1; b.rnd_in = b0;
    tick();
    b.rnd_in = b1;
    tick();
    b.rnd_valid = 1'b0;
  endtask

  task automatic b_release();
    b.dec_ready = 1'b1;
    tick();
    b.dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic dm, dv;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++; if (a.dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid got %b want 0", a.dec_valid); end
    n_checks++; if (a.trial_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_trial_cnt got %0d want 0", a.trial_cnt); end
    n_checks++; if (a.ratio_ready !== 1'b1 || a.rnd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got ratio=%b rnd=%b want 1/0", a.ratio_ready, a.rnd_ready); end
    // Abort a trial after one byte
    a.ratio_in = 17'h10000; a.ratio_valid = 1'b1; tick();
    a.ratio_valid = 1'b0; a.rnd_valid = 1'b1; a.rnd_in = 8'hAA; tick();
    a.rnd_valid = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++; if (a.dec_valid !== 1'b0 || a.ratio_ready !== 1'b1 || a.rnd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state got dv=%b rr=%b nr=%b want 0/1/0", a.dec_valid, a.ratio_ready, a.rnd_ready); end
    n_checks++; if (a.trial_cnt !== 16'd0 || a.accept_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", a.trial_cnt, a.accept_cnt); end
    a_gather(17'h10000, 8'h12, 8'h34, dm, dv);
    n_checks++; if (dm !== 1'b0 || dv !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_latency got %b%b want 01", dm, dv); end
    n_checks++; if (a.dec_u !== 16'h1234) begin n_fail++; $display("FAIL rst_fresh_u got %h want 1234", a.dec_u); end
    a_release();
    n_checks++; if (a.trial_cnt !== 16'd1 || a.accept_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_fresh_cnt got %0d/%0d want 1/1", a.trial_cnt, a.accept_cnt); end
  endtask

  task automatic test_basic();
    logic dm, dv;
    a_gather(17'h08000, 8'h7F, 8'hFF, dm, dv);
    n_checks++; if (dm !== 1'b0 || dv !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b%b want 01", dm, dv); end
    n_checks++; if (a.dec_u !== 16'h7FFF || a.dec_accept !== 1'b1) begin n_fail++; $display("FAIL basic_7fff got u=%h acc=%b want 7fff/1", a.dec_u, a.dec_accept); end
    a_release();
    a_gather(17'h08000, 8'h80, 8'h00, dm, dv);
    n_checks++; if (a.dec_u !== 16'h8000 || a.dec_accept !== 1'b0) begin n_fail++; $display("FAIL basic_8000 got u=%h acc=%b want 8000/0", a.dec_u, a.dec_accept); end
    a_release();
    n_checks++; if (a.trial_cnt !== 16'd3 || a.accept_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_cnt got %0d/%0d want 3/2", a.trial_cnt, a.accept_cnt); end
    n_checks++; if (a.ratio_ready !== 1'b1 || a.dec_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got rr=%b dv=%b want 1/0", a.ratio_ready, a.dec_valid); end
  endtask

  task automatic test_boundaries();
    logic dm, dv;
    a_gather(17'h00000, 8'h00, 8'h00, dm, dv);
    n_checks++; if (a.dec_accept !== 1'b0) begin n_fail++; $display("FAIL bnd_ratio0 got %b want 0", a.dec_accept); end
    a_release();
    a_gather(17'h10000, 8'hFF, 8'hFF, dm, dv);
    n_checks++; if (a.dec_accept !== 1'b1 || a.dec_u !== 16'hFFFF) begin n_fail++; $display("FAIL bnd_ratio1 got u=%h acc=%b want ffff/1", a.dec_u, a.dec_accept); end
    a_release();
    a_gather(17'h1FFFF, 8'hFF, 8'hFF, dm, dv);
    n_checks++; if (a.dec_accept !== 1'b1) begin n_fail++; $display("FAIL bnd_ratio_over got %b want 1", a.dec_accept); end
    a_release();
    a_gather(17'h00001, 8'h00, 8'h00, dm, dv);
    n_checks++; if (a.dec_accept !== 1'b1) begin n_fail++; $display("FAIL bnd_ratio_lsb got %b want 1", a.dec_accept); end
    a_release();
    n_checks++; if (a.trial_cnt !== 16'd7 || a.accept_cnt !== 16'd5) begin n_fail++; $display("FAIL bnd_cnt got %0d/%0d want 7/5", a.trial_cnt, a.accept_cnt); end
  endtask

  task automatic test_backpressure();
    logic dm, dv;
    a_gather(17'h08000, 8'h01, 8'h02, dm, dv);
    a.rnd_valid = 1'b1; a.rnd_in = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (a.dec_valid !== 1'b1 || a.dec_u !== 16'h0102 || a.dec_accept !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got dv=%b u=%h acc=%b want 1/0102/1", i, a.dec_valid, a.dec_u, a.dec_accept); end
      n_checks++; if (a.rnd_ready !== 1'b0 || a.ratio_ready !== 1'b0 || a.trial_cnt !== 16'd7) begin n_fail++; $display("FAIL bp_ctrl[%0d] got nr=%b rr=%b cnt=%0d want 0/0/7", i, a.rnd_ready, a.ratio_ready, a.trial_cnt); end
    end
    a.rnd_valid = 1'b0;
    a_release();
    n_checks++; if (a.trial_cnt !== 16'd8 || a.accept_cnt !== 16'd6) begin n_fail++; $display("FAIL bp_cnt got %0d/%0d want 8/6", a.trial_cnt, a.accept_cnt); end
    n_checks++; if (a.dec_valid !== 1'b0 || a.ratio_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle got dv=%b rr=%b want 0/1", a.dec_valid, a.ratio_ready); end
  endtask

  task automatic test_stall();
    a.ratio_in = 17'h05AC4; a.ratio_valid = 1'b1; tick();
    a.ratio_valid = 1'b0; a.ratio_in = 17'h00000;
    a.rnd_valid = 1'b1; a.rnd_in = 8'h5A; tick();
    a.rnd_valid = 1'b0; a.rnd_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (a.dec_valid !== 1'b0 || a.rnd_ready !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got dv=%b nr=%b want 0/1", i, a.dec_valid, a.rnd_ready); end
    end
    a.rnd_valid = 1'b1; a.rnd_in = 8'hC3; tick();
    a.rnd_valid = 1'b0;
    n_checks++; if (a.dec_valid !== 1'b1 || a.dec_u !== 16'h5AC3) begin n_fail++; $display("FAIL stall_u got dv=%b u=%h want 1/5ac3", a.dec_valid, a.dec_u); end
    n_checks++; if (a.dec_accept !== 1'b1) begin n_fail++; $display("FAIL stall_latched_ratio got %b want 1", a.dec_accept); end
    a_release();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      b_gather(17'h10000, 8'h00, 8'h01);
      b_release();
      if (i == 9) begin
        n_checks++; if (b.trial_cnt !== 4'd10 || b.accept_cnt !== 4'd10) begin n_fail++; $display("FAIL sat_mid got %0d/%0d want 10/10", b.trial_cnt, b.accept_cnt); end
      end
    end
    n_checks++; if (b.trial_cnt !== 4'd15 || b.accept_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_top got %0d/%0d want 15/15", b.trial_cnt, b.accept_cnt); end
    b_gather(17'h10000, 8'h00, 8'h01);
    b.clr_cnt = 1'b1; b.dec_ready = 1'b1;
    tick();
    b.clr_cnt = 1'b0; b.dec_ready = 1'b0;
    n_checks++; if (b.trial_cnt !== 4'd0 || b.accept_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_on_handshake got %0d/%0d want 0/0", b.trial_cnt, b.accept_cnt); end
    n_checks++; if (b.dec_valid !== 1'b0 || b.ratio_ready !== 1'b1) begin n_fail++; $display("FAIL clr_fsm got dv=%b rr=%b want 0/1", b.dec_valid, b.ratio_ready); end
    b_gather(17'h00000, 8'h00, 8'h01);
    b_release();
    n_checks++; if (b.trial_cnt !== 4'd1 || b.accept_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_after got %0d/%0d want 1/0", b.trial_cnt, b.accept_cnt); end
  endtask

  initial begin
    a.rnd_in = 8'h00; a.rnd_valid = 1'b0; a.ratio_in = 17'h0; a.ratio_valid = 1'b0;
    a.dec_ready = 1'b0; a.clr_cnt = 1'b0;
    b.rnd_in = 8'h00; b.rnd_valid = 1'b0; b.ratio_in = 17'h0; b.ratio_valid = 1'b0;
    b.dec_ready = 1'b0; b.clr_cnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
